// File: rtl/vram_dp.sv
// vram_dp: character video RAM with one write port and one registered, read-first read port.
module vram_dp #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  r_en,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // Unreset array keeps block-RAM inference; writes are dropped while reset is held.
  always_ff @(posedge clk)
    if (w_en && rst_n) mem[write_addr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dout <= '0;
    else if (r_en) dout <= mem[read_addr];
endmodule

// File: tb/tb_vram_dp.sv
// tb_vram_dp: randomized scoreboard bench for vram_dp against an array reference model.
module tb_vram_dp;
  localparam int AW = 10;
  localparam int DW = 6;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [AW-1:0] read_addr = '0, write_addr = '0;
  logic r_en = 1'b0, w_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  int tests = 0, fails = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] q [$];
  logic [DW-1:0] last = '0;
  logic [DW-1:0] exp_v;
  bit rd;

  vram_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .read_addr(read_addr), .write_addr(write_addr),
    .r_en(r_en), .w_en(w_en), .din(din), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: dout=%h expected=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a read returns the word as it was before any same-edge write.
  always @(posedge clk)
    if (rst_n) begin
      if (r_en) q.push_back(model[read_addr]);
      if (w_en) model[write_addr] = din;
    end

  always @(posedge clk) begin
    rd = rst_n && r_en;
    #1;
    if (!rst_n) begin
      last = '0;
      check("reset", dout, '0);
    end else if (rd) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: read with no expected entry at %0t", $time);
      end else begin
        exp_v = q.pop_front();
        last = exp_v;
        check("read", dout, exp_v);
      end
    end else check("hold", dout, last);
  end

  task automatic cyc(input bit r, input int ra, input bit w, input int wa, input int d);
    @(negedge clk);
    r_en = r;
    read_addr = AW'(ra);
    w_en = w;
    write_addr = AW'(wa);
    din = DW'(d);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1, $urandom_range(0, DEPTH-1), 1, i, $urandom);
    @(negedge clk);
    rst_n = 1'b1;
    r_en = 1'b1; read_addr = '0; w_en = 1'b0;
    cyc(0, 0, 1, 5, 'h2A);
    cyc(0, 0, 1, 959, 'h15);
    cyc(0, 0, 1, 12, 'h01);
    cyc(1, 5, 0, 0, 0);
    cyc(1, 959, 0, 0, 0);
    cyc(1, 12, 1, 12, 'h3F);
    cyc(1, 12, 0, 0, 0);
    cyc(1, 5, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 959, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom_range(0, 1),
          $urandom_range(0, DEPTH-1), $urandom);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, i, (i & 'h3F) ^ 'h15);
    for (int i = 0; i < DEPTH; i++) cyc(1, i, 0, 0, 0);
    cyc(0, 0, 1, 12, 'h3F);
    cyc(1, 12, 0, 0, 0);
    cyc(0, 959, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", dout, '0);
    cyc(1, 5, 1, 12, 'h07);
    cyc(1, 7, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    r_en = 1'b0;
    w_en = 1'b0;
    cyc(1, 12, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected reads outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
